// File: rtl/bcd_entry.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_entry
//  Purpose  : Decimal keypad entry buffer. Digits keyed one at a time are
//             held as packed BCD (echoed for the 7-segment display). On
//             enter, the buffer is converted to binary most-significant
//             digit first (acc = acc*10 + digit, one digit per cycle). The
//             result is delivered with a one-cycle valid pulse.
//  Ports    : clk        - system clock
//             rst        - asynchronous, active-low reset
//             digit_stb  - digit-entry strobe
//             digit      - digit value, sampled together with digit_stb
//             enter      - start conversion of the current buffer
//             clear      - discard the current entry
//             bcd        - packed BCD echo, newest digit in the low nibble
//             count      - number of digits currently held (0..NDIG)
//             busy       - high while a conversion is in progress
//             data_out   - last converted binary value
//             data_valid - one-cycle pulse when data_out updates
//             err        - one-cycle pulse when a digit is rejected
//  Options  : BCD_ENTRY_SYNC_EN - when defined, digit_stb/enter/clear pass
//             through a 2-flop synchronizer and a rising-edge detector, so
//             a held level triggers exactly one action.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_entry #(
    parameter int NDIG  = 4,
    parameter int OUT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                digit_stb,
    input  logic [3:0]          digit,
    input  logic                enter,
    input  logic                clear,
    output logic [4*NDIG-1:0]   bcd,
    output logic [2:0]          count,
    output logic                busy,
    output logic [OUT_W-1:0]    data_out,
    output logic                data_valid,
    output logic                err
);

    localparam int         c_IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [2:0] c_NDIG_CNT = 3'(NDIG);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CONV = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Per-cycle action requests, bit order {clear, enter, digit_stb}
    logic [2:0] w_act;

`ifdef BCD_ENTRY_SYNC_EN
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_prev;

    // Two synchronizer flops, then a third flop for edge detection. An input
    // rising before edge E1 produces its action at edge E3.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_prev  <= 3'b000;
        end else begin
            r_sync1 <= {clear, enter, digit_stb};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_act = r_sync2 & ~r_prev;
`else
    assign w_act = {clear, enter, digit_stb};
`endif

    logic                r_busy;
    logic [1:0]          r_state;
    logic [4*NDIG-1:0]   r_bcd;
    logic [2:0]          r_count;
    logic [OUT_W-1:0]    r_acc;
    logic [c_IDX_W-1:0]  r_idx;
    logic [OUT_W-1:0]    r_data_out;
    logic                r_data_valid;
    logic                r_err;

    logic [3:0]          w_nibble;
    logic [OUT_W-1:0]    w_acc_next;

    assign w_nibble   = r_bcd[{r_idx, 2'b00} +: 4];
    // acc*10 as (acc<<3)+(acc<<1); valid BCD input keeps this from overflowing
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {{(OUT_W-4){1'b0}}, w_nibble};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_busy       <= 1'b0;
            r_bcd        <= '0;
            r_count      <= 3'd0;
            r_acc        <= '0;
            r_idx        <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // Priority clear > enter > digit_stb; losers are dropped silently
                    if (w_act[2]) begin
                        r_bcd   <= '0;
                        r_count <= 3'd0;
                    end else if (w_act[1]) begin
                        r_acc   <= '0;
                        r_idx   <= c_IDX_W'(NDIG - 1);
                        r_state <= c_CONV;
                        r_busy  <= 1'b1;
                    end else if (w_act[0]) begin
                        if ((digit > 4'd9) || (r_count == c_NDIG_CNT)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_bcd   <= {r_bcd[4*NDIG-5:0], digit};
                            r_count <= r_count + 3'd1;
                        end
                    end
                end
                c_CONV: begin
                    r_acc <= w_acc_next;
                    if (r_idx == '0) begin
                        // Result is registered on the final digit so it is
                        // already visible during the DONE cycle with the pulse.
                        r_data_out   <= w_acc_next;
                        r_data_valid <= 1'b1;
                        r_state      <= c_DONE;
                    end else begin
                        r_idx <= r_idx - c_IDX_W'(1);
                    end
                end
                c_DONE: begin
                    r_bcd   <= '0;
                    r_count <= 3'd0;
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd        = r_bcd;
    assign count      = r_count;
    assign busy       = r_busy;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_entry
//  Purpose  : Directed self-checking bench for bcd_entry (default build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_entry;

    logic        clk;
    logic        rst;
    logic        digit_stb;
    logic [3:0]  digit;
    logic        enter;
    logic        clear;
    logic [15:0] bcd;
    logic [2:0]  count;
    logic        busy;
    logic [15:0] data_out;
    logic        data_valid;
    logic        err;

    int n_tests;
    int n_fail;

    bcd_entry #(.NDIG(4), .OUT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_stb  (digit_stb),
        .digit      (digit),
        .enter      (enter),
        .clear      (clear),
        .bcd        (bcd),
        .count      (count),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        digit_stb = 1'b1;
        digit     = d;
        step();
        digit_stb = 1'b0;
        digit     = 4'd0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bcd"},   32'(bcd),        32'h0);
        chk({tag, "_count"}, 32'(count),      32'h0);
        chk({tag, "_busy"},  32'(busy),       32'h0);
        chk({tag, "_dout"},  32'(data_out),   32'h0);
        chk({tag, "_dv"},    32'(data_valid), 32'h0);
        chk({tag, "_err"},   32'(err),        32'h0);
    endtask

    // enter, then walk the NDIG+1 busy cycles; optionally hold digit_stb
    // during CONV to show it is ignored while busy
    task automatic do_enter(input string tag, input logic [15:0] exp, input logic [15:0] bcd_hold,
                            input bit poke);
        enter = 1'b1;
        step();
        enter = 1'b0;
        if (poke) begin
            digit_stb = 1'b1;
            digit     = 4'd7;
        end
        for (int i = 1; i <= 4; i++) begin
            chk({tag, "_busy_conv"}, 32'(busy),       32'h1);
            chk({tag, "_dv_conv"},   32'(data_valid), 32'h0);
            if (poke) begin
                chk({tag, "_bcd_conv"}, 32'(bcd), 32'(bcd_hold));
                chk({tag, "_err_conv"}, 32'(err), 32'h0);
            end
            step();
        end
        digit_stb = 1'b0;
        digit     = 4'd0;
        chk({tag, "_busy_done"}, 32'(busy),       32'h1);
        chk({tag, "_dv_done"},   32'(data_valid), 32'h1);
        chk({tag, "_dout_done"}, 32'(data_out),   32'(exp));
        step();
        chk({tag, "_busy_after"},  32'(busy),       32'h0);
        chk({tag, "_dv_after"},    32'(data_valid), 32'h0);
        chk({tag, "_bcd_after"},   32'(bcd),        32'h0);
        chk({tag, "_count_after"}, 32'(count),      32'h0);
        chk({tag, "_dout_hold"},   32'(data_out),   32'(exp));
        chk({tag, "_err_after"},   32'(err),        32'h0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        digit_stb = 1'b0;
        digit     = 4'd0;
        enter     = 1'b0;
        clear     = 1'b0;

        // Reset state
        step();
        step();
        chk_zero("reset");
        rst = 1'b1;
        step();
        chk_zero("post_reset");

        // 1,2,3,4 then enter -> 1234
        press(4'd1);
        chk("d1_bcd", 32'(bcd), 32'h0001);
        chk("d1_count", 32'(count), 32'd1);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        chk("d1234_bcd", 32'(bcd), 32'h1234);
        chk("d1234_count", 32'(count), 32'd4);
        chk("d1234_err", 32'(err), 32'h0);
        do_enter("conv1234", 16'h04D2, 16'h0000, 1'b0);

        // 9,9,9,9 then a rejected fifth digit
        press(4'd9);
        press(4'd9);
        press(4'd9);
        press(4'd9);
        press(4'd5);
        chk("full_err", 32'(err), 32'h1);
        chk("full_bcd", 32'(bcd), 32'h9999);
        chk("full_count", 32'(count), 32'd4);
        step();
        chk("full_err_pulse", 32'(err), 32'h0);
        do_enter("conv9999", 16'h270F, 16'h9999, 1'b1);

        // Reset asserted mid-conversion
        press(4'd5);
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
        chk("midrst_busy_pre", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_dv_after", 32'(data_valid), 32'h0);
            chk("midrst_busy_after", 32'(busy), 32'h0);
            chk("midrst_dout_after", 32'(data_out), 32'h0);
        end

        // Non-decimal digit rejected, then 4,2 -> 42
        press(4'hC);
        chk("bad_err", 32'(err), 32'h1);
        chk("bad_count", 32'(count), 32'd0);
        chk("bad_bcd", 32'(bcd), 32'h0);
        step();
        chk("bad_err_pulse", 32'(err), 32'h0);
        press(4'd4);
        press(4'd2);
        chk("d42_bcd", 32'(bcd), 32'h0042);
        chk("d42_count", 32'(count), 32'd2);
        do_enter("conv42", 16'h002A, 16'h0000, 1'b0);

        // Empty buffer enter -> 0
        do_enter("conv_empty", 16'h0000, 16'h0000, 1'b0);

        // clear beats digit_stb in the same cycle
        press(4'd3);
        chk("pri_pre_count", 32'(count), 32'd1);
        clear     = 1'b1;
        digit_stb = 1'b1;
        digit     = 4'd7;
        step();
        clear     = 1'b0;
        digit_stb = 1'b0;
        digit     = 4'd0;
        chk("pri_bcd", 32'(bcd), 32'h0);
        chk("pri_count", 32'(count), 32'd0);
        chk("pri_err", 32'(err), 32'h0);
        step();
        chk("pri_err_next", 32'(err), 32'h0);

        // enter beats digit_stb: conversion of the 1-digit buffer, digit dropped
        press(4'd6);
        enter     = 1'b1;
        digit_stb = 1'b1;
        digit     = 4'd8;
        step();
        enter     = 1'b0;
        digit_stb = 1'b0;
        digit     = 4'd0;
        chk("pri2_busy", 32'(busy), 32'h1);
        chk("pri2_bcd", 32'(bcd), 32'h0006);
        for (int i = 0; i < 4; i++) step();
        chk("pri2_dv", 32'(data_valid), 32'h1);
        chk("pri2_dout", 32'(data_out), 32'h0006);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
